// File: rtl/ps2_pkg.sv
// Shared Set-2 scancode constants, decoder state and key-event type for ps2_scancode.
package ps2_pkg;

  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_BRK     = 8'hF0;
  localparam logic [7:0] SC_PAUSE   = 8'hE1;
  localparam logic [7:0] SC_ACK     = 8'hFA;
  localparam logic [7:0] SC_BAT     = 8'hAA;
  localparam logic [7:0] SC_ECHO    = 8'hEE;
  localparam logic [7:0] SC_RESEND  = 8'hFE;
  localparam logic [7:0] SC_OVR_LO  = 8'h00;
  localparam logic [7:0] SC_OVR_HI  = 8'hFF;

  // Bytes after E1 that make up the rest of the pause sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ps2_ev_t;

  localparam int EV_W = $bits(ps2_ev_t);

  function automatic logic is_proto(input logic [7:0] b);
    return (b == SC_ACK) || (b == SC_BAT) || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through key-event FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [EV_W-1:0] wdata,
  input  logic            pop,
  output logic [EV_W-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic            push_ok
);

  localparam int AW = $clog2(DEPTH);

  logic [EV_W-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign push_ok = push & (~full | do_pop);
  // Head reads zero while empty so the event outputs are clean out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_scancode.sv
// Set-2 scancode decoder: strips E0/F0/E1 prefixes and queues key events.
// Define TYPEMATIC_FILTER_EN to drop repeated makes of a key already held.
module ps2_scancode
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             frame_err,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_rel,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       last_make,
  output logic             overflow,
  output logic             kb_overrun,
  output logic [ERR_W-1:0] err_cnt
);

  ps2_state_e state, state_nxt;
  logic [2:0] skip_cnt, skip_nxt;
  logic       dec_push, push, push_ok, err_inc, ovr_set;
  logic       fifo_full, fifo_empty;
  ps2_ev_t    dec_ev, head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    dec_push  = 1'b0;
    dec_ev    = '{byte_in, 1'b0, 1'b0};
    err_inc   = 1'b0;
    ovr_set   = 1'b0;
    if (byte_valid) begin
      if (frame_err) begin
        state_nxt = ST_IDLE;
        skip_nxt  = '0;
        err_inc   = 1'b1;
      end else if (state == ST_PAUSE) begin
        // Pause tail bytes are swallowed whatever their value.
        if (skip_cnt <= 3'd1) begin
          dec_push  = 1'b1;
          dec_ev    = '{SC_PAUSE, 1'b1, 1'b0};
          state_nxt = ST_IDLE;
          skip_nxt  = '0;
        end else begin
          skip_nxt = skip_cnt - 3'd1;
        end
      end else if (byte_in == SC_OVR_LO || byte_in == SC_OVR_HI) begin
        state_nxt = ST_IDLE;
        ovr_set   = 1'b1;
      end else if (!is_proto(byte_in)) begin
        unique case (state)
          ST_IDLE: begin
            if (byte_in == SC_EXT) state_nxt = ST_EXT;
            else if (byte_in == SC_BRK) state_nxt = ST_BRK;
            else if (byte_in == SC_PAUSE) begin
              state_nxt = ST_PAUSE;
              skip_nxt  = PAUSE_TAIL;
            end else dec_push = 1'b1;
          end
          ST_EXT: begin
            if (byte_in == SC_BRK) state_nxt = ST_EXT_BRK;
            else if (byte_in != SC_EXT) begin
              dec_push  = 1'b1;
              dec_ev    = '{byte_in, 1'b1, 1'b0};
              state_nxt = ST_IDLE;
            end
          end
          ST_BRK: begin
            dec_push  = 1'b1;
            dec_ev    = '{byte_in, 1'b0, 1'b1};
            state_nxt = ST_IDLE;
          end
          ST_EXT_BRK: begin
            dec_push  = 1'b1;
            dec_ev    = '{byte_in, 1'b1, 1'b1};
            state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [511:0] held;
  logic [8:0]   key;
  logic         filt;

  assign key  = {dec_ev.ext, dec_ev.code};
  // The pause event has no break, so it never enters the held map.
  assign filt = (state != ST_PAUSE);
  assign push = dec_push & ~(filt & ~dec_ev.rel & held[key]);

  always_ff @(posedge clk) begin
    if (rst || ovr_set) held <= '0;
    else if (dec_push && filt) held[key] <= ~dec_ev.rel;
  end
`else
  assign push = dec_push;
`endif

  ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (dec_ev),
    .pop     (ev_ready),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok)
  );

  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_rel   = head.rel;
  assign ev_valid = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_make  <= '0;
      overflow   <= 1'b0;
      kb_overrun <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (push_ok && !dec_ev.rel) last_make <= dec_ev.code;
      if (push && !push_ok) overflow <= 1'b1;
      if (ovr_set) kb_overrun <= 1'b1;
      if (err_inc && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
